// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the instruction-memory fetch responder.
package instr_mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned LAT_CNT_W  = 4;
    localparam int unsigned WIDX_W     = 30;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Full word index of a byte address; range checking is left to the caller.
    function automatic logic [WIDX_W-1:0] word_index(input logic [31:0] byte_addr);
        return WIDX_W'(byte_addr >> $clog2(WORD_BYTES));
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: synchronous write, combinational read, no reset.
module imem_array #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = 8
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/instr_mem_responder.sv
// Fetch-side memory responder: fixed-latency word reads with a one-cycle mfc pulse.
// Optional one-entry last-hit buffer enabled with `define LAST_HIT_EN.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       rdata,
    output logic              mfc,
    output logic              busy,
    output logic              err_range,
    output logic              err_align,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_t               state_q, state_d;
    logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]    lat_addr_q, lat_addr_d;
    logic                 hit_q, hit_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 mfc_q, mfc_d;
    logic                 busy_q, busy_d;
    logic                 err_range_q, err_range_d;
    logic                 err_align_q, err_align_d;

    logic                 capture, use_live, req_hit;
    logic [ADDR_W-1:0]    cap_addr;
    logic [WIDX_W-1:0]    req_widx, cap_widx, wr_widx;
    logic                 req_oor, cap_oor, cap_mis, wr_ok;
    logic [IDX_W-1:0]     req_idx, cap_idx, wr_idx;
    logic [31:0]          arr_rdata, hit_data, cap_data;

    // Address decode for the live request, the read capture and the write port
    assign req_widx = word_index(32'(addr));
    assign req_oor  = (req_widx >= WIDX_W'(DEPTH_WORDS));
    assign req_idx  = IDX_W'(req_widx);

    assign cap_addr = use_live ? addr : lat_addr_q;
    assign cap_widx = word_index(32'(cap_addr));
    assign cap_oor  = (cap_widx >= WIDX_W'(DEPTH_WORDS));
    assign cap_mis  = (cap_addr[1:0] != 2'b00);
    assign cap_idx  = IDX_W'(cap_widx);

    assign wr_widx  = word_index(32'(wr_addr));
    assign wr_ok    = wr_en && (wr_widx < WIDX_W'(DEPTH_WORDS));
    assign wr_idx   = IDX_W'(wr_widx);

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .rd_idx  (cap_idx),
        .rd_data (arr_rdata)
    );

`ifdef LAST_HIT_EN
    logic             buf_valid_q, buf_valid_d;
    logic [IDX_W-1:0] buf_idx_q, buf_idx_d;
    logic [31:0]      buf_data_q, buf_data_d;

    // Refill on every in-range completion; any write to the held word drops it
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_idx_d   = buf_idx_q;
        buf_data_d  = buf_data_q;
        if (capture && !cap_oor) begin
            buf_valid_d = 1'b1;
            buf_idx_d   = cap_idx;
            buf_data_d  = cap_data;
        end
        if (wr_ok && (wr_idx == buf_idx_d)) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_idx_q   <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_idx_q   <= buf_idx_d;
            buf_data_q  <= buf_data_d;
        end
    end

    // A write to the same word on the accepting edge would make the buffer stale
    assign req_hit  = buf_valid_q && !req_oor && (buf_idx_q == req_idx)
                      && !(wr_ok && (wr_idx == req_idx));
    assign hit_data = buf_data_q;
`else
    assign req_hit  = 1'b0;
    assign hit_data = arr_rdata;
`endif

    assign cap_data = cap_oor ? 32'd0 : ((hit_q && !use_live) ? hit_data : arr_rdata);

    // A request taken in DONE overlaps its first latency cycle with the completion cycle,
    // so back-to-back fetches complete every LATENCY edges.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_addr_d = lat_addr_q;
        hit_d      = hit_q;
        capture    = 1'b0;
        use_live   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (req) begin
                    lat_addr_d = addr;
                    hit_d      = req_hit;
                    if (req_hit) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else if (state_q == ST_IDLE) begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_CNT_W'(LATENCY - 1);
                    end else if (LATENCY == 1) begin
                        state_d  = ST_DONE;
                        capture  = 1'b1;
                        use_live = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_CNT_W'(LATENCY - 2);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Error flags live only for the completion cycle; rdata holds until the next one
    always_comb begin
        mfc_d       = capture;
        busy_d      = (state_d == ST_WAIT);
        rdata_d     = capture ? cap_data : rdata_q;
        err_range_d = capture && cap_oor;
        err_align_d = capture && cap_mis;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lat_addr_q  <= '0;
            hit_q       <= 1'b0;
            rdata_q     <= '0;
            mfc_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_range_q <= 1'b0;
            err_align_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_addr_q  <= lat_addr_d;
            hit_q       <= hit_d;
            rdata_q     <= rdata_d;
            mfc_q       <= mfc_d;
            busy_q      <= busy_d;
            err_range_q <= err_range_d;
            err_align_q <= err_align_d;
        end
    end

    assign rdata     = rdata_q;
    assign mfc       = mfc_q;
    assign busy      = busy_q;
    assign err_range = err_range_q;
    assign err_align = err_align_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: edge-level reference model, directed and random stimulus.
module tb_instr_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset, req, wr_en;
    logic [31:0] addr, wr_addr, wr_data;
    logic [31:0] rdata;
    logic        mfc, busy, err_range, err_align;

    instr_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .addr      (addr),
        .rdata     (rdata),
        .mfc       (mfc),
        .busy      (busy),
        .err_range (err_range),
        .err_align (err_align),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: memory image plus the single outstanding fetch
    logic [31:0] mem [256];
    int          e_cnt       = 0;
    int          m_done_edge = 0;
    int          m_last_done = -100;
    logic        m_pend      = 1'b0;
    logic [31:0] m_addr      = '0;
    logic        bvalid      = 1'b0;
    logic [7:0]  bidx        = '0;

    logic [31:0] exp_rdata = '0;
    logic        exp_mfc   = 1'b0;
    logic        exp_busy  = 1'b0;
    logic        exp_erng  = 1'b0;
    logic        exp_eal   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, e_cnt);
    endtask

    task automatic compare_all();
        chk("mfc",       32'(mfc),       32'(exp_mfc));
        chk("busy",      32'(busy),      32'(exp_busy));
        chk("rdata",     rdata,          exp_rdata);
        chk("err_range", 32'(err_range), 32'(exp_erng));
        chk("err_align", 32'(err_align), 32'(exp_eal));
    endtask

    // Predict the outputs after one rising edge with the given inputs
    task automatic model_edge(input logic r, input logic rq, input logic [31:0] a,
                              input logic we, input logic [31:0] wa, input logic [31:0] wd);
        logic w_ok, was_pend, oor, hit;
        logic [7:0] widx;
        int lat;
        e_cnt++;
        w_ok = we && !(|wa[31:10]);
        widx = wa[9:2];
        if (r) begin
            m_pend = 1'b0; m_last_done = -100; bvalid = 1'b0;
            exp_mfc = 1'b0; exp_busy = 1'b0; exp_rdata = '0; exp_erng = 1'b0; exp_eal = 1'b0;
            if (w_ok) mem[widx] = wd;
            return;
        end
        was_pend = m_pend;
        exp_mfc = 1'b0; exp_erng = 1'b0; exp_eal = 1'b0;
        if (m_pend && m_done_edge == e_cnt) begin
            oor       = |m_addr[31:10];
            exp_mfc   = 1'b1;
            exp_erng  = oor;
            exp_eal   = (m_addr[1:0] != 2'b00);
            exp_rdata = oor ? 32'd0 : mem[m_addr[9:2]];
            m_pend    = 1'b0;
            m_last_done = e_cnt;
            if (!oor) begin bvalid = 1'b1; bidx = m_addr[9:2]; end
        end
        if (!was_pend && rq) begin
            hit = 1'b0;
`ifdef LAST_HIT_EN
            hit = bvalid && !(|a[31:10]) && (a[9:2] == bidx) && !(w_ok && widx == a[9:2]);
`endif
            if (hit)                          lat = 1;
            else if (m_last_done == e_cnt - 1) lat = LAT - 1;
            else                              lat = LAT;
            m_pend = 1'b1; m_done_edge = e_cnt + lat; m_addr = a;
        end
        if (w_ok && bvalid && widx == bidx) bvalid = 1'b0;
        if (w_ok) mem[widx] = wd;
        exp_busy = m_pend;
    endtask

    task automatic step(input logic r, input logic rq, input logic [31:0] a,
                        input logic we, input logic [31:0] wa, input logic [31:0] wd);
        reset = r; req = rq; addr = a; wr_en = we; wr_addr = wa; wr_data = wd;
        model_edge(r, rq, a, we, wa, wd);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] a);
        step(1'b0, 1'b1, a, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic write(input logic [31:0] wa, input logic [31:0] wd);
        step(1'b0, 1'b0, 32'd0, 1'b1, wa, wd);
    endtask

    function automatic logic [31:0] gen_addr();
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0:       return $urandom;
            1:       return 32'h400 | 32'($urandom_range(0, 1023));
            2:       return 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(1, 3));
            3, 4:    return 32'($urandom_range(0, 255)) * 4;
            default: return 32'($urandom_range(0, 15)) * 4;
        endcase
    endfunction

    initial begin
        logic [31:0] d;
        logic        r, rq, we;
        logic [31:0] a, wa, wd;

        reset = 1'b1; req = 1'b0; addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        @(negedge clk);
        @(negedge clk);
        compare_all();
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mfc", 32'(mfc), 32'd0);

        // Preload: words 0..7 fixed, word 4 = 0xDEADBEEF, the rest random
        for (int i = 0; i < 256; i++) begin
            d = (i < 8) ? 32'h1000_0000 + 32'(i) : $urandom;
            if (i == 4) d = 32'hDEAD_BEEF;
            write(32'(i * 4), d);
        end

        // Single fetch: mfc exactly two edges after the request edge
        fetch(32'h10);
        chk("t1_mfc_e0", 32'(mfc), 32'd0);
        chk("t1_busy_e0", 32'(busy), 32'd1);
        idle();
        chk("t1_mfc_e1", 32'(mfc), 32'd0);
        idle();
        chk("t1_mfc_e2", 32'(mfc), 32'd1);
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        chk("t1_errs", {30'd0, err_range, err_align}, 32'd0);
        idle();
        chk("t1_mfc_e3", 32'(mfc), 32'd0);
        chk("t1_hold", rdata, 32'hDEAD_BEEF);

        // req held high: completions every two edges, in order
        fetch(32'h0);
        fetch(32'h0);
        fetch(32'h4);
        chk("t2_mfc0", 32'(mfc), 32'd1);
        chk("t2_data0", rdata, 32'h1000_0000);
        fetch(32'h4);
        chk("t2_gap0", 32'(mfc), 32'd0);
        fetch(32'h8);
        chk("t2_mfc1", 32'(mfc), 32'd1);
        chk("t2_data1", rdata, 32'h1000_0001);
        fetch(32'h8);
        chk("t2_gap1", 32'(mfc), 32'd0);
        idle();
        chk("t2_mfc2", 32'(mfc), 32'd1);
        chk("t2_data2", rdata, 32'h1000_0002);
        idle();
        idle();

        // Misaligned and out-of-range requests
        write(32'h10, 32'hDEAD_BEEF);
        fetch(32'h12);
        idle();
        idle();
        chk("t3_align", 32'(err_align), 32'd1);
        chk("t3_align_data", rdata, 32'hDEAD_BEEF);
        idle();
        chk("t3_align_clr", 32'(err_align), 32'd0);
        fetch(32'h400);
        idle();
        idle();
        chk("t3_range", 32'(err_range), 32'd1);
        chk("t3_range_data", rdata, 32'd0);
        idle();

        // Reset during WAIT aborts the fetch; the array keeps its contents
        fetch(32'h8);
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        chk("t4_rst_out", {rdata[29:0], mfc, busy}, 32'd0);
        idle();
        idle();
        idle();
        chk("t4_no_mfc", 32'(mfc), 32'd0);
        fetch(32'h18);
        idle();
        idle();
        chk("t4_after", rdata, 32'h1000_0006);
        idle();

        // Write on the capture edge returns old data; one edge earlier returns new
        fetch(32'h14);
        idle();
        write(32'h14, 32'hCAFE_0001);
        chk("t5_rbw", rdata, 32'h1000_0005);
        idle();
        fetch(32'h14);
        write(32'h14, 32'hCAFE_0002);
        idle();
        chk("t5_new", rdata, 32'hCAFE_0002);
        idle();

`ifdef LAST_HIT_EN
        fetch(32'h10);
        idle();
        idle();
        idle();
        fetch(32'h10);
        idle();
        chk("t6_hit_mfc", 32'(mfc), 32'd1);
        chk("t6_hit_data", rdata, 32'hDEAD_BEEF);
        idle();
        write(32'h10, 32'h5A5A_5A5A);
        fetch(32'h10);
        idle();
        chk("t6_miss_e1", 32'(mfc), 32'd0);
        idle();
        chk("t6_miss_data", rdata, 32'h5A5A_5A5A);
        idle();
`endif

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 99) == 0);
            rq = 1'($urandom_range(0, 1));
            a  = gen_addr();
            we = ($urandom_range(0, 9) < 3) && !r;
            wa = gen_addr();
            wd = $urandom;
            step(r, rq, a, we, wa, wd);
        end
        for (int c = 0; c < 4; c++) idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
